// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: FSM state encoding,
// ALU opcode constants and default widths.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OP_W   = 4;
  localparam int DEF_CNT_W  = 16;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational. A lone requester always
// wins; when both request, the one named by Prio wins.
module rr_arbiter2 (
  input  logic Req0,
  input  logic Req1,
  input  logic Prio,
  output logic GntVld,
  output logic GntId
);

  // Grant decision: single request wins outright, a tie goes to Prio.
  always_comb begin
    GntVld = Req0 | Req1;
    GntId  = 1'b0;
    if (Req0 && Req1) begin
      GntId = Prio;
    end else if (Req1) begin
      GntId = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters. The winner's operands
// are latched into registers that drive the ALU, the result is captured one
// cycle later and a one-cycle Ack is returned to the winner.
module alu_share_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic [DATA_W-1:0] A0,
  input  logic [DATA_W-1:0] B0,
  input  logic [OP_W-1:0]   Op0,
  input  logic              Req1,
  input  logic [DATA_W-1:0] A1,
  input  logic [DATA_W-1:0] B1,
  input  logic [OP_W-1:0]   Op1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [DATA_W-1:0] Res,
  output logic              ResZero,
  output logic              Busy,
  output logic [CNT_W-1:0]  OpCount,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [OP_W-1:0]   ALU_Op,
  input  logic [DATA_W-1:0] ALU_Out,
  input  logic              ALU_Zero
);

  state_t            state;
  logic              gnt_id;
  logic              prio;
  logic              arb_vld;
  logic              arb_id;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [OP_W-1:0]   op_code;
  logic [DATA_W-1:0] res;
  logic              res_zero;
  logic [CNT_W-1:0]  op_count;

  rr_arbiter2 u_arb (
    .Req0   (Req0),
    .Req1   (Req1),
    .Prio   (prio),
    .GntVld (arb_vld),
    .GntId  (arb_id)
  );

  // Controller: grant in IDLE, capture the ALU result in EXEC, acknowledge in DONE.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      gnt_id   <= 1'b0;
      prio     <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_code  <= '0;
      res      <= '0;
      res_zero <= 1'b0;
      op_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            op_a    <= arb_id ? A1  : A0;
            op_b    <= arb_id ? B1  : B0;
            op_code <= arb_id ? Op1 : Op0;
            gnt_id  <= arb_id;
            prio    <= ~arb_id;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res      <= ALU_Out;
          res_zero <= ALU_Zero;
          op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
          state    <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Ack is decoded from state and grant id; an asserted reset suppresses it so a
  // discarded operation never acknowledges.
  always_comb begin
    Ack0 = (state == ST_DONE) && !gnt_id && Reset;
    Ack1 = (state == ST_DONE) &&  gnt_id && Reset;
    Busy = (state != ST_IDLE);
  end

  assign Res     = res;
  assign ResZero = res_zero;
  assign OpCount = op_count;
  assign ALU_A   = op_a;
  assign ALU_B   = op_b;
  assign ALU_Op  = op_code;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single 32-bit ALU between two requesters, for example the main datapath and a branch/address unit.
- Arbitrates round-robin and latches the winner's operands into registers that drive the ALU.
- Captures Out/Zero into result registers and returns them with a one-cycle acknowledge to the winner.
- Keeps a wrapping count of completed operations for debug.

Parameters:
- DATA_W, 32, operand/result width; must match ALU A/B/Out.
- OP_W, 4, ALU opcode width; must match ALU Op.
- CNT_W, 16, width of completed-operation counter.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Req0  in  1  requester 0 request; held high until Ack0.
- A0, B0  in  DATA_W  requester 0 operands; stable while Req0 high.
- Op0  in  OP_W  requester 0 ALU opcode.
- Req1, A1, B1, Op1  in  1/DATA_W/DATA_W/OP_W  requester 1, same rules.
- Ack0, Ack1  out  1  one-cycle completion pulse to the granted requester.
- Res  out  DATA_W  registered ALU result of the last completed op.
- ResZero  out  1  registered ALU Zero of the last completed op.
- Busy  out  1  high whenever state != IDLE.
- OpCount  out  CNT_W  completed operations, wraps modulo 2^CNT_W.
- ALU_A, ALU_B  out  DATA_W  to ALU A/B; driven from operand registers.
- ALU_Op  out  OP_W  to ALU Op; from opcode register.
- ALU_Out  in  DATA_W  from ALU Out.
- ALU_Zero  in  1  from ALU Zero.

Behaviour:
- Reset (Reset==0 at edge):
  - state=IDLE; Ack0/Ack1=0; Res=0; ResZero=0; ALU_A/ALU_B/ALU_Op=0.
  - OpCount=0; round-robin pointer Prio=0 (requester 0 favoured).
  - Overrides every other event.
- FSM states IDLE, EXEC, DONE, in one-hot or binary encoding from the shared package.
- IDLE:
  - If no Req, stay in IDLE.
  - If exactly one Req, grant it.
  - If both Req, grant requester Prio.
  - At the edge: latch the winner's A/B/Op into the operand registers, record Gnt id, set Prio = ~Gnt id, go to EXEC.
- EXEC:
  - ALU is combinational; operand registers are already on ALU_A/B/Op.
  - At the edge: Res<=ALU_Out, ResZero<=ALU_Zero, OpCount<=OpCount+1 (wraps), go to DONE.
- DONE:
  - Ack of the granted requester =1 (combinational from state and Gnt id); the other Ack=0.
  - Res/ResZero valid.
  - Go to IDLE unconditionally.
- Latency: Req sampled in IDLE cycle t; Ack high in cycle t+2; next grant earliest at edge ending t+3.
- Throughput: one op per 3 cycles.
- Requester protocol:
  - Deassert Req in the cycle after Ack.
  - A Req still high in the following IDLE cycle is a new request.
  - Changing operands while Req is high and not yet granted is allowed; the values latched are those present in the IDLE grant cycle.
- The non-granted requester waits with Req high. With both continuously requesting, grants strictly alternate, so no starvation.
- Res/ResZero hold until the next EXEC capture. ALU_* hold the last operands after completion.
- Reset mid-operation (EXEC or DONE): the in-flight op is discarded, no Ack, OpCount not incremented.
- Ack0 and Ack1 are never high in the same cycle.
- Busy=0 only in IDLE.

Decomposition:
- Shared package/header alu_ctrl_pkg holds:
  - FSM state encodings (IDLE/EXEC/DONE).
  - ALU opcode constants (OP_AND=4'b0000, OP_OR=4'b0001, OP_ADD=4'b0010, OP_SUB=4'b0110).
  - Default widths.
- One sub-module, rr_arbiter2. Inputs Req0, Req1, Prio. Outputs Gnt valid and Gnt id. Purely combinational, reusable for other two-way shared resources.
- Operand/result registers, FSM and counter stay in the top module.

Test Plan:
- Reset: hold Reset=0 for 2 cycles with Req0=1 -> Ack0/Ack1=0, Res=0, OpCount=0, Busy=0; after release, first grant goes to requester 0.
- Single op: Req0=1, A0=32'd1, B0=32'd2, Op0=OP_ADD -> Ack0 high exactly 2 cycles after the grant cycle, Res=32'd3, ResZero=0, OpCount=1, Ack1 never high.
- Zero flag: Req1=1, A1=B1=32'h0000000F, Op1=OP_SUB -> Ack1 pulse, Res=0, ResZero=1.
- Contention: Req0=Req1=1 continuously; op0 = 5 ADD 5, op1 = 8'hF0 OR 8'h0F -> Ack order 0,1,0,1; Res alternates 10 and 32'h000000FF; one Ack every 3 cycles.
- Reset mid-op: drive Reset=0 during EXEC -> no Ack, OpCount unchanged at its prior value (0 after reset), state IDLE next cycle.
- Counter wrap: CNT_W=4, run 17 ops -> OpCount reads 1.
